msk_sbox_layer_sequencer: RTL and testbench
===========================================

// Module: msk_sbox_layer_sequencer
// PURPOSE
//  Drives the masked dual-sbox bank: serialises a d-share state into 2**PDSBOX column bundles.
//  Tracks the bank's fixed 3-cycle pipeline and reassembles results into a registered shared state.
//  Sits between the Clyde round controller and the sbox bank; gates progress on randomness availability.
// PARAMETERS
//  d       2    number of masking shares
//  PDSBOX  0    log2 of number of column bundles NB=2**PDSBOX (0..5)
//  Nbits   128  state bits; bundle width BW=d*Nbits/NB, 32/NB columns per bundle
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           asynchronous active-low reset
//  start          in   1           1-cycle request; accepted only when busy=0
//  inverse        in   1           0: forward sbox, 1: inverse; sampled at accepted start
//  state_in       in   d*Nbits     shared state, column-major 4*d bits/column; held stable while busy
//  rnd_valid      in   1           randomness bus of the bank is fresh this cycle
//  rnd_consume    out  1           PRNG advance strobe (= sb_enable)
//  sb_cols        out  BW          bundle to bank input cols
//  sb_inverse     out  1           to bank inverse
//  sb_enable      out  1           to bank enable (freezes bank pipeline when 0)
//  sb_cols_post   in   BW          bank output cols_post_sb
//  state_out      out  d*Nbits     registered shared result
//  busy           out  1           operation in progress
//  done           out  1           1-cycle pulse, state_out complete
// BEHAVIOUR
//  Reset: busy=0, done=0, sb_enable=0, rnd_consume=0, sb_inverse=0, state_out=0, FSM=IDLE.
//  FSM IDLE -> RUN on start&!busy; RUN -> FIN when last writeback stepped; FIN -> IDLE after 1 cycle (done=1).
//  Step = RUN & rnd_ok; sb_enable = step; counter c (0..NB+2) increments on each step, cleared in IDLE.
//  Issue: while c<NB, sb_cols = state_in[c*BW +: BW]; else sb_cols = 0 (drain, shares all zero).
//  Writeback: on a step edge with c>=3, state_out[(c-3)*BW +: BW] <= sb_cols_post (bank latency 3).
//  Last step at c=NB+2; stall-free op: NB+3 RUN cycles, done NB+4 cycles after start edge.
//  Stall (rnd_ok=0): sb_enable=0, c and state_out hold; bank contents frozen so results stay aligned.
//  start while busy: ignored. start in FIN cycle: ignored (busy=1 through FIN).
//  sb_inverse registered at start, constant for whole operation.
//  Reset mid-operation: immediate return to reset values; bank pipeline contents are don't-care.
//  state_out bits not yet written keep previous operation's value until overwritten.
// CONFIGURATION
//  SBSEQ_RND_STALL_EN defined: rnd_ok = rnd_valid; stalls as above.
//  Undefined: rnd_ok = 1; rnd_valid ignored; sequencer never stalls (PRNG must supply every cycle).
// STRUCTURE
//  Package msk_sbox_pkg: localparam SB_LATENCY=3; function bundle_width(d,Nbits,PDSBOX); FSM state enum.
//  Sub-module sbseq_ctrl: FSM + counter c, produces step, issue index, writeback index/enable.
//  Top keeps bundle mux and state_out register; sbox bank instantiated by parent, not here.
// TESTING (d=2, Nbits=128 unless noted; compare against unmasked Clyde sbox on XOR of shares)
//  PDSBOX=2, rnd_valid=1, start -> sb_enable high 7 cycles, done 8 cycles after start, state_out correct.
//  PDSBOX=0 -> sb_enable high 4 cycles, done at cycle 5, single 256-bit bundle written at c=3.
//  STALL_EN, PDSBOX=2, rnd_valid=0 for 2 cycles at c=2 -> done at cycle 10, result identical to no stall.
//  start pulsed again at c=1 and during FIN -> ignored; exactly one done pulse, c unaffected.
//  rst_n low at c=4 -> busy, done, sb_enable drop asynchronously, state_out=0; new start completes correctly.
//  inverse=1 on forward result -> state_out unmasks to original plaintext state.

Source files
------------

// File: rtl/msk_sbox_pkg.sv
// msk_sbox_pkg: shared constants, bundle sizing and FSM states for the sbox layer sequencer.
package msk_sbox_pkg;
    localparam int SB_LATENCY = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} sbseq_state_e;
    function automatic int bundle_width(input int d, input int nbits, input int pdsbox);
        return d * nbits / (1 << pdsbox);
    endfunction
endpackage

// File: rtl/sbseq_ctrl.sv
// sbseq_ctrl: sequencing FSM and bundle counter producing step, issue and writeback controls.
module sbseq_ctrl
    import msk_sbox_pkg::*;
#(
    parameter int NB = 1,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          inverse,
    input  logic          rnd_ok,
    output logic          step,
    output logic          busy,
    output logic          done,
    output logic          sb_inverse,
    output logic          issue_en,
    output logic [CW-1:0] issue_idx,
    output logic          wb_en,
    output logic [CW-1:0] wb_idx
);
    localparam logic [CW-1:0] C_NB   = CW'(NB);
    localparam logic [CW-1:0] C_LAT  = CW'(SB_LATENCY);
    localparam logic [CW-1:0] C_LAST = CW'(NB + SB_LATENCY - 1);
    sbseq_state_e  r_state;
    logic [CW-1:0] r_c;
    logic          r_busy, r_done, r_inv;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                    r_inv   <= inverse;
                    r_c     <= '0;
                end
                ST_RUN: if (step) begin
                    r_c <= (r_c == C_LAST) ? '0 : r_c + 1'b1;
                    if (r_c == C_LAST) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_c     <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign step       = (r_state == ST_RUN) && rnd_ok;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sb_inverse = r_inv;
    assign issue_en   = r_c < C_NB;
    assign issue_idx  = r_c;
    assign wb_en      = step && (r_c >= C_LAT);
    assign wb_idx     = r_c - C_LAT;
endmodule

// File: rtl/msk_sbox_layer_sequencer.sv
// msk_sbox_layer_sequencer: feeds a d-share state through the 3-cycle masked sbox bank bundle by bundle and reassembles the result.
// Define SBSEQ_RND_STALL_EN to hold the sequence while rnd_valid is low.
module msk_sbox_layer_sequencer
    import msk_sbox_pkg::*;
#(
    parameter int d      = 2,
    parameter int PDSBOX = 0,
    parameter int Nbits  = 128,
    localparam int NB = 1 << PDSBOX,
    localparam int BW = bundle_width(d, Nbits, PDSBOX),
    localparam int CW = $clog2(NB + SB_LATENCY)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               inverse,
    input  logic [d*Nbits-1:0] state_in,
    input  logic               rnd_valid,
    output logic               rnd_consume,
    output logic [BW-1:0]      sb_cols,
    output logic               sb_inverse,
    output logic               sb_enable,
    input  logic [BW-1:0]      sb_cols_post,
    output logic [d*Nbits-1:0] state_out,
    output logic               busy,
    output logic               done
);
    logic               w_rnd_ok, w_step, w_issue_en, w_wb_en;
    logic [CW-1:0]      w_issue_idx, w_wb_idx;
    logic [d*Nbits-1:0] r_state_out;
`ifdef SBSEQ_RND_STALL_EN
    assign w_rnd_ok = rnd_valid;
`else
    logic w_unused_rnd;
    assign w_unused_rnd = rnd_valid;
    assign w_rnd_ok     = 1'b1;
`endif
    sbseq_ctrl #(.NB(NB), .CW(CW)) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .inverse    (inverse),
        .rnd_ok     (w_rnd_ok),
        .step       (w_step),
        .busy       (busy),
        .done       (done),
        .sb_inverse (sb_inverse),
        .issue_en   (w_issue_en),
        .issue_idx  (w_issue_idx),
        .wb_en      (w_wb_en),
        .wb_idx     (w_wb_idx)
    );
    assign sb_enable   = w_step;
    assign rnd_consume = w_step;
    // Past the last bundle the bank is fed all-zero shares while it drains.
    assign sb_cols = w_issue_en ? state_in[int'(w_issue_idx)*BW +: BW] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state_out <= '0;
        else if (w_wb_en) r_state_out[int'(w_wb_idx)*BW +: BW] <= sb_cols_post;
    end
    assign state_out = r_state_out;
endmodule

// File: tb/tb_msk_sbox_layer_sequencer.sv
// tb_msk_sbox_layer_sequencer: scoreboard bench driving PDSBOX=2 and PDSBOX=0 sequencers against a masked Clyde sbox bank model.
module tb_msk_sbox_layer_sequencer;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         start2 = 1'b0, start0 = 1'b0, inverse = 1'b0, rnd_valid = 1'b1;
    logic [255:0] si2 = '0, si0 = '0;
    logic [63:0]  cols2, post2;
    logic [255:0] cols0, post0;
    logic         en2_o, en0_o, cons2, cons0, inv2, inv0, busy2, busy0, done2, done0;
    logic [255:0] out2, out0;
    int           n_total = 0, n_bad = 0;
    logic [127:0] q2[$], q0[$];

    always #5 clk = ~clk;

    msk_sbox_layer_sequencer #(.d(2), .PDSBOX(2), .Nbits(128)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .inverse(inverse), .state_in(si2),
        .rnd_valid(rnd_valid), .rnd_consume(cons2), .sb_cols(cols2), .sb_inverse(inv2),
        .sb_enable(en2_o), .sb_cols_post(post2), .state_out(out2), .busy(busy2), .done(done2)
    );
    msk_sbox_layer_sequencer #(.d(2), .PDSBOX(0), .Nbits(128)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .inverse(inverse), .state_in(si0),
        .rnd_valid(rnd_valid), .rnd_consume(cons0), .sb_cols(cols0), .sb_inverse(inv0),
        .sb_enable(en0_o), .sb_cols_post(post0), .state_out(out0), .busy(busy0), .done(done0)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic y0, y1, y2, y3;
        y1 = (x[0] & x[1]) ^ x[2];
        y0 = (x[3] & x[0]) ^ x[1];
        y3 = (y1 & x[3]) ^ x[0];
        y2 = (y0 & y1) ^ x[3];
        return {y3, y2, y1, y0};
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] y);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (sbox(4'(i)) == y) r = 4'(i);
        return r;
    endfunction

    // Column j holds share 0 in bits [8j+3:8j] and share 1 in bits [8j+7:8j+4].
    function automatic logic [255:0] bank_f(input logic [255:0] x, input logic [255:0] m, input logic inv);
        logic [255:0] y;
        logic [3:0]   u, v;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            u = x[j*8 +: 4] ^ x[j*8+4 +: 4];
            v = inv ? sbox_inv(u) : sbox(u);
            y[j*8 +: 8] = {m[j*4 +: 4], v ^ m[j*4 +: 4]};
        end
        return y;
    endfunction

    function automatic logic [127:0] unmask(input logic [255:0] s);
        logic [127:0] r;
        for (int j = 0; j < 32; j++) r[j*4 +: 4] = s[j*8 +: 4] ^ s[j*8+4 +: 4];
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [255:0] s, input logic inv);
        logic [127:0] u, r;
        u = unmask(s);
        for (int j = 0; j < 32; j++) r[j*4 +: 4] = inv ? sbox_inv(u[j*4 +: 4]) : sbox(u[j*4 +: 4]);
        return r;
    endfunction

    function automatic logic [255:0] share(input logic [127:0] p, input logic [127:0] m);
        logic [255:0] s;
        for (int j = 0; j < 32; j++) s[j*8 +: 8] = {m[j*4 +: 4], p[j*4 +: 4] ^ m[j*4 +: 4]};
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Bank model: three enable-gated stages, fresh output mask every cycle.
    logic [255:0] mask = '0, f2, f0;
    logic [63:0]  p2a = '0, p2b = '0, p2c = '0;
    logic [255:0] p0a = '0, p0b = '0, p0c = '0;
    assign f2 = bank_f({192'b0, cols2}, mask, inv2);
    assign f0 = bank_f(cols0, mask, inv0);
    always @(posedge clk) begin
        mask <= {rnd128(), rnd128()};
        if (en2_o) begin p2a <= f2[63:0]; p2b <= p2a; p2c <= p2b; end
        if (en0_o) begin p0a <= f0; p0b <= p0a; p0c <= p0b; end
    end
    assign post2 = p2c;
    assign post0 = p0c;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() != 0) check("result2", 256'(unmask(out2)), 256'(q2.pop_front()));
            else check("spurious_done2", 256'(done2), 256'd0);
        end
        if (done0) begin
            if (q0.size() != 0) check("result0", 256'(unmask(out0)), 256'(q0.pop_front()));
            else check("spurious_done0", 256'(done0), 256'd0);
        end
    end

    task automatic op(input logic [255:0] s2, input logic [255:0] s0, input logic [127:0] e2,
                      input logic [127:0] e0, input logic inv, input bit restart);
        int en2 = 0, en0 = 0, cn2 = 0, cn0 = 0, dn2 = 0, dn0 = 0, dw2 = -1, dw0 = -1, st = 0;
        logic [255:0] prev2, prev0;
`ifdef SBSEQ_RND_STALL_EN
        st = 2;
`endif
        @(negedge clk);
        prev2 = out2;
        prev0 = out0;
        si2 = s2; si0 = s0; inverse = inv; start2 = 1'b1; start0 = 1'b1;
        q2.push_back(e2);
        q0.push_back(e0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start2 = restart && (k == 2 || k == 8);
            start0 = restart && (k == 2 || k == 5);
            rnd_valid = !(k == 3 || k == 4);
            if (k == 1) inverse = !inv;
            #1;
            en2 += int'(en2_o); cn2 += int'(cons2); en0 += int'(en0_o); cn0 += int'(cons0);
            if (done2) begin dn2++; dw2 = k; check("busy_fin2", 256'(busy2), 256'd1); end
            if (done0) begin dn0++; dw0 = k; check("busy_fin0", 256'(busy0), 256'd1); end
            if (k == 1) check("issue2", 256'(cols2), 256'(s2[63:0]));
            if (k == 1) check("issue0", cols0, s0);
            if (k == 3) check("sb_inv2", 256'(inv2), 256'(inv));
            if (k == 4) check("hold2", out2, prev2);
            if (k == 4) check("hold0", out0, prev0);
        end
        rnd_valid = 1'b1;
        check("en_cycles2", 256'(en2), 256'(7));
        check("consume2", 256'(cn2), 256'(7));
        check("done_at2", 256'(dw2), 256'(8 + st));
        check("done_cnt2", 256'(dn2), 256'(1));
        check("en_cycles0", 256'(en0), 256'(4));
        check("consume0", 256'(cn0), 256'(4));
        check("done_at0", 256'(dw0), 256'(5 + st));
        check("done_cnt0", 256'(dn0), 256'(1));
        check("idle2", 256'({busy2, en2_o}), 256'd0);
        check("pending2", 256'(q2.size()), 256'd0);
        check("pending0", 256'(q0.size()), 256'd0);
    endtask

    initial begin
        logic [127:0] p, pk;
        logic [255:0] s;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctl2", 256'({busy2, done2, en2_o, cons2, inv2}), 256'd0);
        check("rst_out2", out2, '0);
        check("rst_ctl0", 256'({busy0, done0, en0_o, cons0, inv0}), 256'd0);
        check("rst_out0", out0, '0);
        p = '0;
        s = share(p, rnd128());
        op(s, s, model(s, 1'b0), model(s, 1'b0), 1'b0, 1'b0);
        pk = rnd128();
        s = share(pk, rnd128());
        op(s, s, model(s, 1'b0), model(s, 1'b0), 1'b0, 1'b1);
        op(out2, out0, pk, pk, 1'b1, 1'b0);
        p = '1;
        s = share(p, rnd128());
        op(s, s, model(s, 1'b0), model(s, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        si2 = share(rnd128(), rnd128());
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre_rst_busy2", 256'(busy2), 256'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl2", 256'({busy2, done2, en2_o, cons2}), 256'd0);
        check("mid_rst_out2", out2, '0);
        check("mid_rst_out0", out0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        pk = rnd128();
        s = share(pk, rnd128());
        op(s, s, model(s, 1'b0), model(s, 1'b0), 1'b0, 1'b0);
        check("post_rst_fwd2", 256'(unmask(out2)), 256'(model(s, 1'b0)));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
